// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address field helpers for the data cache.
package dcache_pkg;

  localparam int LINE_BITS   = 512;
  localparam int WORDS       = 16;
  localparam int OFFSET_BITS = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_DONE,
    S_WB_REQ,
    S_WB_WAIT,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_FILL_WRITE
  } state_e;

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned index_bits);
    return a >> (OFFSET_BITS + index_bits);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned index_bits);
    return (a >> OFFSET_BITS) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [3:0] addr_word(input logic [31:0] a);
    return a[5:2];
  endfunction

endpackage

// File: rtl/dcache_ram.sv
// Single-port synchronous RAM, one-cycle read latency; a write returns the new data.
module dcache_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
      r_rdata     <= wdata;
    end else begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller with whole-line
// writeback/fill bursts towards an Avalon burst master.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | waiting for a CPU request; RAM read at the request index
// S_LOOKUP     | tag compare; hit completes, miss starts writeback or fill
// S_DONE       | request complete, cpu_stall low for this one cycle
// S_WB_REQ     | mem_write pulse with the victim line
// S_WB_WAIT    | wait for write busy to rise and then fall
// S_FILL_REQ   | mem_read pulse for the requested line
// S_FILL_WAIT  | wait for read busy to rise and then fall
// S_FILL_WRITE | write fetched line and tag, re-read for the lookup
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [31:0]          cpu_addr,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_be,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic [31:0]          mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [LINE_BITS-1:0] mem_write_value,
  output logic [4:0]           mem_burstcount,
  input  logic                 mem_wait,
  input  logic                 mem_write_ready_n,
  input  logic [LINE_BITS-1:0] mem_read_value
);

  localparam int TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  state_e                 r_state;
  logic [LINES-1:0]       r_valid;
  logic [LINES-1:0]       r_dirty;
  logic                   r_seen;
  logic                   r_mem_read;
  logic                   r_mem_write;
  logic [31:0]            r_mem_address;
  logic [LINE_BITS-1:0]   r_mem_write_value;
  logic [31:0]            r_cpu_rdata;

  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_index;
  logic [3:0]             w_word;
  logic [TAG_BITS-1:0]    w_tag_rdata;
  logic [LINE_BITS-1:0]   w_data_rdata;
  logic                   w_hit;
  logic                   w_is_write;
  logic [31:0]            w_rd_word;
  logic [31:0]            w_merged_word;
  logic [LINE_BITS-1:0]   w_merged_line;
  logic                   w_data_we;
  logic [LINE_BITS-1:0]   w_data_wdata;
  logic                   w_tag_we;

  assign w_tag      = TAG_BITS'(addr_tag(cpu_addr, INDEX_BITS));
  assign w_index    = INDEX_BITS'(addr_index(cpu_addr, INDEX_BITS));
  assign w_word     = addr_word(cpu_addr);
  assign w_is_write = cpu_write;
  assign w_hit      = r_valid[w_index] && (w_tag_rdata == w_tag);

  always_comb begin
    w_rd_word     = w_data_rdata[32*w_word +: 32];
    w_merged_word = w_rd_word;
    for (int b = 0; b < 4; b++) begin
      if (cpu_be[b]) w_merged_word[8*b +: 8] = cpu_wdata[8*b +: 8];
    end
    w_merged_line = w_data_rdata;
    w_merged_line[32*w_word +: 32] = w_merged_word;
  end

  // The CPU holds its address for the whole request, so the RAMs always index by it.
  assign w_tag_we     = (r_state == S_FILL_WRITE);
  assign w_data_we    = (r_state == S_FILL_WRITE) || ((r_state == S_LOOKUP) && w_hit && w_is_write);
  assign w_data_wdata = (r_state == S_FILL_WRITE) ? mem_read_value : w_merged_line;

  dcache_ram #(.WIDTH(LINE_BITS), .DEPTH(LINES)) u_data_ram (
    .clk   (clk),
    .we    (w_data_we),
    .addr  (w_index),
    .wdata (w_data_wdata),
    .rdata (w_data_rdata)
  );

  dcache_ram #(.WIDTH(TAG_BITS), .DEPTH(LINES)) u_tag_ram (
    .clk   (clk),
    .we    (w_tag_we),
    .addr  (w_index),
    .wdata (w_tag),
    .rdata (w_tag_rdata)
  );

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state           <= S_IDLE;
      r_valid           <= '0;
      r_dirty           <= '0;
      r_seen            <= 1'b0;
      r_mem_read        <= 1'b0;
      r_mem_write       <= 1'b0;
      r_mem_address     <= '0;
      r_mem_write_value <= '0;
      r_cpu_rdata       <= '0;
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_read || cpu_write) r_state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (w_hit) begin
            if (w_is_write) r_dirty[w_index] <= 1'b1;
            else            r_cpu_rdata      <= w_rd_word;
            r_state <= S_DONE;
          end else if (r_valid[w_index] && r_dirty[w_index]) begin
            r_mem_write       <= 1'b1;
            r_mem_address     <= {w_tag_rdata, w_index, {OFFSET_BITS{1'b0}}};
            r_mem_write_value <= w_data_rdata;
            r_state           <= S_WB_REQ;
          end else begin
            r_mem_read    <= 1'b1;
            r_mem_address <= {w_tag, w_index, {OFFSET_BITS{1'b0}}};
            r_state       <= S_FILL_REQ;
          end
        end
        S_DONE: r_state <= S_IDLE;
        S_WB_REQ: begin
          r_seen  <= 1'b0;
          r_state <= S_WB_WAIT;
        end
        S_WB_WAIT: begin
          // Busy must be seen high first: it only rises a cycle after the pulse.
          if (mem_write_ready_n) begin
            r_seen <= 1'b1;
          end else if (r_seen) begin
            r_dirty[w_index] <= 1'b0;
            r_mem_read       <= 1'b1;
            r_mem_address    <= {w_tag, w_index, {OFFSET_BITS{1'b0}}};
            r_state          <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: begin
          r_seen  <= 1'b0;
          r_state <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (mem_wait)    r_seen  <= 1'b1;
          else if (r_seen) r_state <= S_FILL_WRITE;
        end
        S_FILL_WRITE: begin
          r_valid[w_index] <= 1'b1;
          r_dirty[w_index] <= 1'b0;
          r_state          <= S_LOOKUP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata       = r_cpu_rdata;
  assign cpu_stall       = (cpu_read || cpu_write) && (r_state != S_DONE);
  assign mem_address     = r_mem_address;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_write_value = r_mem_write_value;
  assign mem_burstcount  = 5'd16;

endmodule
